// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Purpose  : Shared widths, direction/type encodings and request bundle for
//             the 64-bit shifter issue path.
//  Revision : 1.0  initial release
// ============================================================================
package shift_pkg;

    localparam int SHIFT_DATA_W = 64;
    localparam int SHIFT_AMT_W  = 7;
    localparam int SHIFT_TAG_W  = 4;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } shift_dir_e;

    typedef enum logic {
        SH_LOGIC = 1'b0,
        SH_ARITH = 1'b1
    } shift_type_e;

    typedef struct packed {
        logic [SHIFT_DATA_W-1:0] data;
        logic [SHIFT_AMT_W-1:0]  amt;
        shift_dir_e              dir;
        shift_type_e             arith;
        logic [SHIFT_TAG_W-1:0]  tag;
    } shift_req_t;

endpackage
`default_nettype wire

// File: rtl/shift_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_issue_stage_if
//  Purpose  : Request and result valid/ready channels of the shifter issue
//             stage. The stage uses the slave view, the requester/consumer
//             side uses the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface shift_issue_stage_if #(
    parameter int AMT_W = 7,
    parameter int TAG_W = 4
);

    // request channel
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             in_arith;
    logic [TAG_W-1:0] in_tag;

    // result channel
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             out_zero;
    logic             out_sat;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, in_arith, in_tag,
        output in_ready,
        output out_valid, out_data, out_zero, out_sat, out_tag,
        input  out_ready
    );

    modport master (
        output in_valid, in_data, in_amt, in_dir, in_arith, in_tag,
        input  in_ready,
        input  out_valid, out_data, out_zero, out_sat, out_tag,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/shift_sat_mux.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sat_mux
//  Purpose  : Selects between the barrel shifter result and the saturated
//             result when the requested amount is 64 or more.
//  Revision : 1.0  initial release
// ============================================================================
module shift_sat_mux
    import shift_pkg::*;
(
    input  wire logic                    i_data_msb,
    input  wire logic [SHIFT_AMT_W-1:0]  i_amt,
    input  shift_dir_e                   i_dir,
    input  shift_type_e                  i_arith,
    input  wire logic [SHIFT_DATA_W-1:0] i_sh_d_out,
    input  wire logic                    i_sh_z,
    output logic      [SHIFT_DATA_W-1:0] o_result,
    output logic                         o_zero,
    output logic                         o_sat
);

    localparam logic [SHIFT_AMT_W-1:0] c_SAT_AMT = SHIFT_AMT_W'(64);

    // Out-of-range amounts: arithmetic right fills with the sign, everything
    // else (left of either type, logical right) shifts every bit out.
    always_comb begin
        o_sat    = (i_amt >= c_SAT_AMT);
        o_result = i_sh_d_out;
        o_zero   = i_sh_z;
        if (o_sat) begin
            if ((i_dir == SH_RIGHT) && (i_arith == SH_ARITH)) begin
                o_result = {SHIFT_DATA_W{i_data_msb}};
                o_zero   = ~i_data_msb;
            end else begin
                o_result = '0;
                o_zero   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shift_issue_stage
//  Purpose  : Two-register issue stage around an external combinational
//             64-bit barrel shifter. S1 holds the operands that drive the
//             shifter, S2 captures the (possibly saturated) result and tag.
//             Full-throughput valid/ready with backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int AMT_W = 7,   // at least 7
    parameter int TAG_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    shift_issue_stage_if.slave bus,
    output logic [63:0]      sh_d_in,
    output logic [5:0]       sh_amt,
    output logic             sh_dir,
    output logic             sh_type,
    input  wire logic [63:0] sh_d_out,
    input  wire logic        sh_z
);

    // S1 operand register
    logic                    v1_q,    v1_d;
    logic [SHIFT_DATA_W-1:0] data_q,  data_d;
    logic [SHIFT_AMT_W-1:0]  amt_q,   amt_d;
    shift_dir_e              dir_q,   dir_d;
    shift_type_e             arith_q, arith_d;
    logic [TAG_W-1:0]        tag_q,   tag_d;

    // S2 result register
    logic                    v2_q,       v2_d;
    logic [SHIFT_DATA_W-1:0] out_data_q, out_data_d;
    logic                    out_zero_q, out_zero_d;
    logic                    out_sat_q,  out_sat_d;
    logic [TAG_W-1:0]        out_tag_q,  out_tag_d;

    logic                    w_s1_load;
    logic                    w_s2_load;
    logic                    w_in_ready;
    logic [SHIFT_AMT_W-1:0]  w_amt_ext;
    logic [SHIFT_DATA_W-1:0] w_result;
    logic                    w_zero;
    logic                    w_sat;

    // Any set bit above bit 5 folds into bit 6, so the 7-bit amount keeps
    // its low six bits for the shifter and still flags >= 64.
    assign w_amt_ext = {|bus.in_amt[AMT_W-1:SHIFT_AMT_W-1], bus.in_amt[SHIFT_AMT_W-2:0]};

    // Handshake: S1 advances into S2 whenever S2 is empty or draining,
    // which also frees S1 for a new accept in the same cycle.
    always_comb begin
        w_s2_load  = v1_q & (~v2_q | bus.out_ready);
        w_in_ready = ~v1_q | w_s2_load;
        w_s1_load  = bus.in_valid & w_in_ready;
    end

    shift_sat_mux u_sat_mux (
        .i_data_msb (data_q[SHIFT_DATA_W-1]),
        .i_amt      (amt_q),
        .i_dir      (dir_q),
        .i_arith    (arith_q),
        .i_sh_d_out (sh_d_out),
        .i_sh_z     (sh_z),
        .o_result   (w_result),
        .o_zero     (w_zero),
        .o_sat      (w_sat)
    );

    // Next-state for both pipeline registers; each holds unless loaded.
    always_comb begin
        v1_d       = v1_q;
        data_d     = data_q;
        amt_d      = amt_q;
        dir_d      = dir_q;
        arith_d    = arith_q;
        tag_d      = tag_q;
        v2_d       = v2_q;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        out_sat_d  = out_sat_q;
        out_tag_d  = out_tag_q;

        if (w_s1_load) begin
            v1_d    = 1'b1;
            data_d  = bus.in_data;
            amt_d   = w_amt_ext;
            dir_d   = shift_dir_e'(bus.in_dir);
            arith_d = shift_type_e'(bus.in_arith);
            tag_d   = bus.in_tag;
        end else if (w_s2_load) begin
            v1_d    = 1'b0;
        end

        if (w_s2_load) begin
            v2_d       = 1'b1;
            out_data_d = w_result;
            out_zero_d = w_zero;
            out_sat_d  = w_sat;
            out_tag_d  = tag_q;
        end else if (bus.out_ready) begin
            v2_d       = 1'b0;
        end
    end

    // Pipeline state; reset empties both stages and clears all data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            data_q     <= '0;
            amt_q      <= '0;
            dir_q      <= SH_LEFT;
            arith_q    <= SH_LOGIC;
            tag_q      <= '0;
            v2_q       <= 1'b0;
            out_data_q <= '0;
            out_zero_q <= 1'b0;
            out_sat_q  <= 1'b0;
            out_tag_q  <= '0;
        end else begin
            v1_q       <= v1_d;
            data_q     <= data_d;
            amt_q      <= amt_d;
            dir_q      <= dir_d;
            arith_q    <= arith_d;
            tag_q      <= tag_d;
            v2_q       <= v2_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
            out_sat_q  <= out_sat_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign sh_d_in       = data_q;
    assign sh_amt        = amt_q[5:0];
    assign sh_dir        = dir_q;
    assign sh_type       = arith_q;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = v2_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_tag   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_issue_stage
//  Purpose  : Directed bench for shift_issue_stage with a behavioural barrel
//             shifter closing the sh_* loop and a queue-based scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] sh_d_in;
    logic [5:0]  sh_amt;
    logic        sh_dir;
    logic        sh_type;
    logic [63:0] sh_d_out;
    logic        sh_z;

    shift_issue_stage_if #(.AMT_W(7), .TAG_W(4)) bus ();

    shift_issue_stage #(.AMT_W(7), .TAG_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sh_d_in  (sh_d_in),
        .sh_amt   (sh_amt),
        .sh_dir   (sh_dir),
        .sh_type  (sh_type),
        .sh_d_out (sh_d_out),
        .sh_z     (sh_z)
    );

    always #5 clk = ~clk;

    // behavioural barrel shifter
    logic signed [63:0] sra_res;
    always_comb begin
        sra_res = $signed(sh_d_in) >>> sh_amt;
        if (sh_dir) begin
            if (sh_type) sh_d_out = sra_res;
            else         sh_d_out = sh_d_in >> sh_amt;
        end else begin
            sh_d_out = sh_d_in << sh_amt;
        end
        sh_z = (sh_d_out == 64'd0);
    end

    typedef struct {
        logic [63:0] data;
        logic        zero;
        logic        sat;
        logic [3:0]  tag;
    } exp_t;

    exp_t        expq[$];
    int          pop_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        held_v = 1'b0;
    logic [63:0] held_data;
    logic [3:0]  held_tag;

    always @(posedge clk) cyc++;

    // monitor: compare every accepted result, and check hold under stall
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else if (bus.out_valid) begin
            if (bus.out_ready) begin
                held_v = 1'b0;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got tag=%0d data=%h, required no output",
                             bus.out_tag, bus.out_data);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    pop_cyc.push_back(cyc);
                    if (bus.out_data !== e.data || bus.out_zero !== e.zero ||
                        bus.out_sat !== e.sat || bus.out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL result: got data=%h zero=%b sat=%b tag=%0d, required data=%h zero=%b sat=%b tag=%0d",
                                 bus.out_data, bus.out_zero, bus.out_sat, bus.out_tag,
                                 e.data, e.zero, e.sat, e.tag);
                    end
                end
            end else begin
                if (held_v) begin
                    checks++;
                    if (bus.out_data !== held_data || bus.out_tag !== held_tag) begin
                        errors++;
                        $display("FAIL hold_stable: got data=%h tag=%0d, required data=%h tag=%0d",
                                 bus.out_data, bus.out_tag, held_data, held_tag);
                    end
                end
                held_v    = 1'b1;
                held_data = bus.out_data;
                held_tag  = bus.out_tag;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [63:0] d, input logic [6:0] amt, input logic dir,
                        input logic arith, input logic [3:0] tag,
                        input logic [63:0] ed, input logic ez, input logic es);
        int waits = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = amt;
        bus.in_dir   = dir;
        bus.in_arith = arith;
        bus.in_tag   = tag;
        @(negedge clk);
        while (!bus.in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, required 1 (tag %0d)", tag);
        end else begin
            e.data = ed; e.zero = ez; e.sat = es; e.tag = tag;
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int waits = 0;
        while (expq.size() != 0 && waits < 50) begin
            @(posedge clk);
            waits++;
        end
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", expq.size());
        end
    endtask

    task automatic chk_consecutive(input string name, input int n);
        checks++;
        if (pop_cyc.size() != n) begin
            errors++;
            $display("FAIL %s: got %0d results, required %0d", name, pop_cyc.size(), n);
        end else begin
            for (int i = 1; i < n; i++) begin
                if (pop_cyc[i] != pop_cyc[i-1] + 1) begin
                    errors++;
                    $display("FAIL %s: got gap at result %0d, required one per cycle", name, i);
                    break;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hDEAD_BEEF_0000_1234;
        bus.in_amt    = 7'd5;
        bus.in_dir    = 1'b0;
        bus.in_arith  = 1'b0;
        bus.in_tag    = 4'd7;
        bus.out_ready = 1'b1;

        // 1. reset with in_valid high
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  bus.out_data,       64'd0);
        chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
        chk("rst_sh_d_in",   sh_d_in,            64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;

        // 2. basic left logical with latency
        send(64'h5, 7'd3, 1'b0, 1'b0, 4'd1, 64'h28, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_early_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // 3. saturation and boundary amounts
        send(64'hFFFF_FFFF_FFFF_FFF0, 7'd70,  1'b1, 1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 7'd64,  1'b1, 1'b1, 4'd3, 64'h0,                   1'b1, 1'b1);
        send(64'h1,                   7'd127, 1'b0, 1'b0, 4'd4, 64'h0,                   1'b1, 1'b1);
        send(64'h8000_0000_0000_0000, 7'd4,   1'b1, 1'b1, 4'd5, 64'hF800_0000_0000_0000, 1'b0, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 7'd64,  1'b1, 1'b0, 4'd6, 64'h0,                   1'b1, 1'b1);
        send(64'h8000_0000_0000_0000, 7'd100, 1'b0, 1'b1, 4'd7, 64'h0,                   1'b1, 1'b1);
        send(64'h8000_0000_0000_0000, 7'd4,   1'b1, 1'b0, 4'd8, 64'h0800_0000_0000_0000, 1'b0, 1'b0);
        send(64'h8000_0000_0000_0000, 7'd63,  1'b1, 1'b1, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        drain();

        // 4. back-to-back throughput
        pop_cyc.delete();
        send(64'h1,   7'd0,  1'b0, 1'b0, 4'd0, 64'h1,                   1'b0, 1'b0);
        send(64'hF0,  7'd4,  1'b1, 1'b0, 4'd1, 64'hF,                   1'b0, 1'b0);
        send(64'h1,   7'd63, 1'b0, 1'b0, 4'd2, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        send(64'h10,  7'd5,  1'b1, 1'b0, 4'd3, 64'h0,                   1'b1, 1'b0);
        drain();
        chk_consecutive("throughput", 4);

        // 5. backpressure: two held, third stalled
        pop_cyc.delete();
        bus.out_ready = 1'b0;
        send(64'h3,    7'd1, 1'b0, 1'b0, 4'd8,  64'h6, 1'b0, 1'b0);
        send(64'h100,  7'd8, 1'b1, 1'b0, 4'd9,  64'h1, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hFF00;
        bus.in_amt   = 7'd8;
        bus.in_dir   = 1'b1;
        bus.in_arith = 1'b1;
        bus.in_tag   = 4'd10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        end
        chk("bp_out_tag", 64'(bus.out_tag), 64'd8);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_high", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) begin
            exp_t e;
            e.data = 64'hFF; e.zero = 1'b0; e.sat = 1'b0; e.tag = 4'd10;
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        chk_consecutive("bp_drain", 3);

        // 6. reset with both stages occupied
        bus.out_ready = 1'b0;
        send(64'hAAAA, 7'd4, 1'b0, 1'b0, 4'd11, 64'hAAAA0, 1'b0, 1'b0);
        send(64'hBBBB, 7'd4, 1'b0, 1'b0, 4'd12, 64'hBBBB0, 1'b0, 1'b0);
        rst = 1'b1;
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send(64'hC, 7'd2, 1'b1, 1'b0, 4'd13, 64'h3, 1'b0, 1'b0);
        @(negedge clk);
        chk("midrst_lat_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("midrst_lat_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_issue_stage.md
# shift_issue_stage

Upstream issue stage for the 64-bit combinational barrel shifter. It accepts shift requests over a valid/ready handshake and registers the operands that drive the shifter. It also extends the shift amount to 7 bits, saturating amounts of 64 and above. The shifter's result and zero flag are captured into an output register with a tag, so downstream logic sees a 2-stage pipeline at one op per cycle with backpressure.

## Interface
- `AMT_W`, default 7: request shift-amount width. Must be at least 7.
- `TAG_W`, default 4: width of the opaque request tag carried to the output.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: stage can accept a request.
- `in_data`, in, 64: operand.
- `in_amt`, in, AMT_W: shift amount, 0..2^AMT_W-1.
- `in_dir`, in, 1: 0 = left, 1 = right.
- `in_arith`, in, 1: 0 = logical, 1 = arithmetic.
- `in_tag`, in, TAG_W: request tag.
- `sh_d_in`, out, 64: to shifter `d_in`.
- `sh_amt`, out, 6: to shifter `sh_amt`.
- `sh_dir`, out, 1: to shifter `dir`.
- `sh_type`, out, 1: to shifter `type`.
- `sh_d_out`, in, 64: from shifter `d_out`.
- `sh_z`, in, 1: from shifter `z`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, 64: shift result.
- `out_zero`, out, 1: result is all zeros.
- `out_sat`, out, 1: request amount was at least 64.
- `out_tag`, out, TAG_W: tag of the result.

## Operation
**S1, operand register.** Holds `v1`, data, `amt[AMT_W-1:0]`, `dir`, `arith` and `tag`.
- `sh_d_in`, `sh_dir` and `sh_type` are driven directly from the S1 registers.
- `sh_amt` = S1 `amt[5:0]`.

**Saturation.** `sat1` = (S1 amt >= 64).
- `sat1` = 0: result = `sh_d_out`, zero = `sh_z`.
- `sat1` = 1 with `dir` = 1 and `arith` = 1: result = {64{data[63]}}, zero = ~data[63].
- `sat1` = 1 otherwise (left of either type, or right logical): result = 0, zero = 1.
- Left arithmetic is identical to left logical.

**S2, result register.** Holds `v2`, `out_data`, `out_zero`, `out_sat`, `out_tag`.

**Advance rules.**
- `s2_load` = v1 & (~v2 | out_ready).
- `s1_load` = in_valid & in_ready.
- `in_ready` = ~v1 | s2_load. This is a combinational path from `out_ready`.

**Valid updates.**
- `v2` next = s2_load ? 1 : (out_ready ? 0 : v2).
- `v1` next = s1_load ? 1 : (s2_load ? 0 : v1).

**Ordering and holding.**
- Strict FIFO order; no reordering and no drops except on reset.
- While out_valid & ~out_ready, all `out_*` signals hold stable.
- While v1 & ~s2_load, all S1 registers and `sh_*` outputs hold stable.

**Reset.** `rst` = 1 at an edge produces:
- v1 = v2 = 0.
- All data registers = 0, so `sh_*` = 0 and `out_data` = 0, `out_zero` = 0, `out_sat` = 0, `out_tag` = 0.
- `in_ready` = 1 in the cycle after reset.
- Reset mid-operation discards both in-flight ops; `in_valid` is ignored during reset.

## Timing
- A request sampled at edge N (in_valid & in_ready) is in S1 after N.
- The shifter evaluates combinationally during cycle N..N+1.
- S2 captures at edge N+1 if `out_ready` or S2 is empty; `out_valid` is high after N+1.
- Latency is 2 edges from acceptance to registered result. Throughput is 1 op per cycle with `out_ready` held high.
- Simultaneous S2 drain and S1 refill in one cycle is allowed.
- Simultaneous S1 → S2 transfer and a new accept in one cycle is allowed.
- With `out_ready` low, at most 2 ops are held. `in_ready` falls when v1 & v2 & ~out_ready.
- No combinational path from `in_*` to `out_*`.

## Structure
- Shared package `shift_pkg`:
  - `SHIFT_DATA_W` = 64, `SHIFT_AMT_W` = 7.
  - enum `shift_dir_e` {SH_LEFT = 0, SH_RIGHT = 1}.
  - enum `shift_type_e` {SH_LOGIC = 0, SH_ARITH = 1}.
  - struct `shift_req_t` {data, amt, dir, arith, tag}.
- One natural combinational sub-module, `shift_sat_mux`: inputs are the S1 fields plus `sh_d_out`/`sh_z`; outputs are result, zero and sat.
- The barrel shifter is instantiated beside this block by the parent and connected through the `sh_*` ports.

## Test plan
1. **Reset.** Hold `rst` for 2 cycles with in_valid = 1 → out_valid = 0, out_data = 0, sh_d_in = 0, and in_ready = 1 after release.
2. **Basic left logical.** data = 0x5, amt = 3, left logical, tag = 1, out_ready = 1 → two edges after acceptance: out_data = 0x28, zero = 0, sat = 0, tag = 1.
3. **Saturation.**
   - data = 0xFFFF_FFFF_FFFF_FFF0, amt = 70, right arithmetic → out_data = 0xFFFF_FFFF_FFFF_FFFF, sat = 1, zero = 0.
   - data = 0x7FFF_FFFF_FFFF_FFFF, amt = 64, right arithmetic → out_data = 0, zero = 1, sat = 1.
   - data = 0x1, amt = 127, left logical → out_data = 0, zero = 1, sat = 1.
4. **Back-to-back throughput.** Tags 0..3 on consecutive cycles with out_ready = 1 → out_valid high for 4 consecutive cycles with tags 0, 1, 2, 3 and correct data.
5. **Backpressure.** out_ready = 0 with 3 requests offered → 2 accepted; in_ready = 0 from the third; out_data/out_tag stable. Then out_ready = 1 → the 3 results drain in order, one per cycle.
6. **Reset mid-flight.** `rst` asserted with v1 = v2 = 1 → next cycle out_valid = 0 and no stale result ever appears; a fresh request then completes with 2-edge latency.
